// File: rtl/alu_mc_pkg.sv
// Shared opcodes and FSM state type for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [2:0] OP_FWD = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SRA = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiply and one-bit-per-cycle shifts.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   n_i,
    output logic [WIDTH-1:0] step_o,
    output logic             last_o
);

    localparam int CW = SHW + 1;

    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;

    always_comb begin
        case (op_q)
            OP_MUL:  step_o = acc_q + (mplier_q[0] ? mcand_q : '0);
            OP_SLL:  step_o = acc_q << 1;
            OP_SRL:  step_o = acc_q >> 1;
            default: step_o = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (op_i == OP_MUL) ? CW'(WIDTH) : {1'b0, n_i};
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // The final step is folded into the result register by the top level.
    assign last_o = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            op_q  <= OP_FWD;
        end else begin
            cnt_q <= cnt_d;
            if (load_i) begin
                op_q <= op_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            acc_q    <= (op_i == OP_MUL) ? '0 : a_i;
            mcand_q  <= a_i;
            mplier_q <= b_i;
        end else if (run_i) begin
            acc_q    <= step_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: control FSM, single-cycle ops and registered outputs.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [SHW-1:0]   shamt;
    logic             multi;
    logic             load;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] step;
    logic             last;

    assign shamt = data2[SHW-1:0];
    assign multi = (select == OP_MUL) || (is_shift(select) && (shamt != '0));
    assign load  = start && (state_q == IDLE) && multi;

    // Zero-distance shifts fall through to the default and return A unchanged.
    always_comb begin
        case (select)
            OP_FWD:  res_d = data2;
            OP_ADD:  res_d = data1 + data2;
            OP_AND:  res_d = data1 & data2;
            OP_OR:   res_d = data1 | data2;
            default: res_d = data1;
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_iter (
        .clk    (CLK),
        .rst    (RESET),
        .load_i (load),
        .run_i  (state_q == RUN),
        .op_i   (select),
        .a_i    (data1),
        .b_i    (data2),
        .n_i    (shamt),
        .step_o (step),
        .last_o (last)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (multi) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            result_q <= res_d;
                            zero_q   <= (res_d == '0);
                            done_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last) begin
                        result_q <= step;
                        zero_q   <= (step == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: random and directed ops against an arithmetic reference.
module tb_alu_mc;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         start;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic [2:0]   select;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic         done;

    alu_mc #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .start  (start),
        .data1  (data1),
        .data2  (data2),
        .select (select),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] res;
        int           edge_n;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   free_edge = 0;
    int   busy_lo   = 1;
    int   busy_hi   = 0;
    bit   mon_en    = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0]        r;
        logic signed [W-1:0] s;
        int                  n;
        n = b % W;
        s = a;
        case (op)
            3'd0: r = b;
            3'd1: r = a + b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a * b;
            3'd5: r = a << n;
            3'd6: r = a >> n;
            default: r = s >>> n;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] b);
        if (op < 3'd4) return 0;
        if (op == 3'd4) return W;
        return b % W;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input bit s, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        exp_t e;
        int   edge_n;
        int   lat;
        @(negedge CLK);
        #1;
        start  = s;
        select = op;
        data1  = a;
        data2  = b;
        edge_n = cyc + 1;
        if (s && edge_n >= free_edge) begin
            lat       = ref_lat(op, b);
            e.res     = ref_res(op, a, b);
            e.edge_n  = edge_n + lat;
            sb.push_back(e);
            free_edge = edge_n + lat + 1;
            if (lat > 0) begin
                busy_lo = edge_n;
                busy_hi = edge_n + lat - 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 3'd0, '0, '0);
    endtask

    task automatic wait_free();
        for (int i = 0; i < 40 && (cyc + 1 < free_edge); i++) issue(1'b0, 3'd0, '0, '0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_result"}, 32'(result), 32'h0);
        chk({tag, "_zero"},   32'(zero),   32'h1);
        chk({tag, "_busy"},   32'(busy),   32'h0);
        chk({tag, "_done"},   32'(done),   32'h0);
    endtask

    always @(negedge CLK) begin
        if (mon_en && !RESET) begin
            exp_t e;
            chk("busy", 32'(busy), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
            if (sb.size() > 0 && cyc > sb[0].edge_n) begin
                e = sb.pop_front();
                chk("done_missing", 32'(cyc), 32'(e.edge_n));
            end
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 32'(cyc), 32'(e.edge_n));
                    chk("result", 32'(result), 32'(e.res));
                    chk("zero", 32'(zero), 32'(e.res == '0));
                end
            end
        end
    end

    initial begin
        RESET  = 1'b1;
        start  = 1'b0;
        select = '0;
        data1  = '0;
        data2  = '0;
        #12;
        chk_reset_vals("por");
        @(negedge CLK);
        #2 RESET = 1'b0;
        mon_en = 1'b1;

        issue(1'b1, 3'd1, 8'd200, 8'd100);  wait_free();
        issue(1'b1, 3'd4, 8'd13, 8'd11);    wait_free();
        issue(1'b1, 3'd4, 8'd20, 8'd13);    wait_free();
        issue(1'b1, 3'd7, 8'h90, 8'd3);     wait_free();
        issue(1'b1, 3'd6, 8'h90, 8'd3);     wait_free();
        issue(1'b1, 3'd5, 8'h81, 8'd0);     wait_free();
        issue(1'b1, 3'd2, 8'h0F, 8'hF0);    wait_free();
        issue(1'b1, 3'd4, 8'h07, 8'h05);
        issue(1'b1, 3'd3, 8'hFF, 8'hFF);    wait_free();
        idle(2);

        // Reset in the fourth cycle of a multiply
        issue(1'b1, 3'd4, 8'h33, 8'h44);
        idle(3);
        @(negedge CLK);
        #2 RESET = 1'b1;
        sb.delete();
        free_edge = 0;
        busy_lo   = 1;
        busy_hi   = 0;
        #1;
        chk_reset_vals("midrun");
        @(negedge CLK);
        #2 RESET = 1'b0;
        issue(1'b1, 3'd0, 8'h00, 8'h5A);    wait_free();

        issue(1'b1, 3'd0, 8'h00, 8'h01);
        issue(1'b1, 3'd1, 8'h01, 8'h01);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            issue(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 60 && sb.size() > 0; i++) idle(1);
        chk("drain_empty", 32'(sb.size()), 32'h0);
        idle(2);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
